// File: rtl/wb_address_decoder.sv
// rtl/wb_address_decoder.sv - Wishbone classic 1:N address decoder with timeout; WB_ERR_CAPTURE_EN adds error capture
package pkg_base_address;
  localparam int NUM_ENTRIES = 5;
  // 0: top module, 1: SFP+ I2C, 2: ethernet, 3: statistics, 4: user design
  localparam logic [NUM_ENTRIES-1:0][31:0] BASE_ADDRESS = {
    32'h8000_5200, 32'h8000_5100, 32'h8000_5080, 32'h8000_5000, 32'h0000_0000
  };
  localparam logic [NUM_ENTRIES-1:0][31:0] MEM_SPACE = {
    32'h0000_0200, 32'h0000_0100, 32'h0000_0080, 32'h0000_0080, 32'h0000_0100
  };
endpackage

module wb_address_decoder #(
  parameter int NUM_SLAVES     = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_cyc,
  input  logic                     m_stb,
  input  logic                     m_we,
  input  logic [31:0]              m_adr,
  input  logic [31:0]              m_dat_i,
  input  logic [3:0]               m_sel,
  output logic [31:0]              m_dat_o,
  output logic                     m_ack,
  output logic                     m_err,
  output logic [NUM_SLAVES-1:0]    s_cyc,
  output logic [NUM_SLAVES-1:0]    s_stb,
  output logic                     s_we,
  output logic [31:0]              s_adr,
  output logic [31:0]              s_dat_o,
  output logic [3:0]               s_sel,
  input  logic [32*NUM_SLAVES-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack,
  input  logic [NUM_SLAVES-1:0]    s_err
`ifdef WB_ERR_CAPTURE_EN
  ,
  output logic [31:0]              err_adr,
  output logic [1:0]               err_cause,
  output logic [15:0]              err_count
`endif
);
  import pkg_base_address::*;

  localparam int IDXW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t                state;
  logic [IDXW-1:0]       idx_q;
  logic [15:0]           tmo_cnt;
  logic                  hit;
  logic [IDXW-1:0]       hit_idx;
  logic [NUM_SLAVES-1:0] hit_onehot;
  logic                  sel_ack;
  logic                  sel_err;
  logic [31:0]           sel_dat;
  logic [32:0]           adr33;

  assign adr33 = {1'b0, m_adr};

  // Descending scan so the lowest matching index wins on overlap; 33-bit end avoids wrap.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (adr33 >= {1'b0, BASE_ADDRESS[i]} &&
          adr33 < ({1'b0, BASE_ADDRESS[i]} + {1'b0, MEM_SPACE[i]})) begin
        hit           = 1'b1;
        hit_idx       = i[IDXW-1:0];
        hit_onehot    = '0;
        hit_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == i[IDXW-1:0]) begin
        sel_ack = s_ack[i];
        sel_err = s_err[i];
        sel_dat = s_dat_i[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx_q   <= '0;
      tmo_cnt <= '0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_dat_o <= '0;
      s_cyc   <= '0;
      s_stb   <= '0;
      s_we    <= 1'b0;
      s_adr   <= '0;
      s_dat_o <= '0;
      s_sel   <= '0;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      case (state)
        IDLE: begin
          if (m_cyc && m_stb) begin
            s_adr   <= m_adr;
            s_we    <= m_we;
            s_dat_o <= m_dat_i;
            s_sel   <= m_sel;
            idx_q   <= hit_idx;
            tmo_cnt <= '0;
            if (hit) begin
              s_cyc <= hit_onehot;
              s_stb <= hit_onehot;
              state <= ACTIVE;
            end else begin
              m_err <= 1'b1;
              state <= RESP;
            end
          end
        end
        ACTIVE: begin
          // Master abort outranks any same-cycle slave response.
          if (!m_cyc) begin
            s_cyc <= '0;
            s_stb <= '0;
            state <= IDLE;
          end else if (sel_err) begin
            s_cyc <= '0;
            s_stb <= '0;
            m_err <= 1'b1;
            state <= RESP;
          end else if (sel_ack) begin
            s_cyc   <= '0;
            s_stb   <= '0;
            m_ack   <= 1'b1;
            m_dat_o <= sel_dat;
            state   <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            s_cyc <= '0;
            s_stb <= '0;
            m_err <= 1'b1;
            state <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_ERR_CAPTURE_EN
  logic        err_event;
  logic [1:0]  err_code;
  logic [31:0] err_addr_nxt;

  always_comb begin
    err_event    = 1'b0;
    err_code     = 2'b00;
    err_addr_nxt = s_adr;
    if (state == IDLE && m_cyc && m_stb && !hit) begin
      err_event    = 1'b1;
      err_code     = 2'b01;
      err_addr_nxt = m_adr;
    end else if (state == ACTIVE && m_cyc) begin
      if (sel_err) begin
        err_event = 1'b1;
        err_code  = 2'b10;
      end else if (!sel_ack && tmo_cnt == TMO_LAST) begin
        err_event = 1'b1;
        err_code  = 2'b11;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_adr   <= '0;
      err_cause <= '0;
      err_count <= '0;
    end else if (err_event) begin
      err_adr   <= err_addr_nxt;
      err_cause <= err_code;
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
